braille_learn_ctrl: RTL and testbench
=====================================

BRAILLE_LEARN_CTRL -- requirements
Module: braille_learn_ctrl

Interface
REQ-001 Parameter DOTS, 6, braille cell width in dots (6 or 8; dots 7/8 SHALL be ignored for decode).
REQ-002 Parameter DEPTH, 8, entry buffer depth in letters (power of 2, 2..64).
REQ-003 Parameter DEB_CYCLES, 16, consecutive stable synchronised samples required to accept a button level.
REQ-004 Parameter HOLD_CYCLES, 50_000_000, display time per letter during replay.
REQ-005 Clk  input  1  single clock; all logic on rising edge.
REQ-006 Rst  input  1  reset, synchronous, active-high.
REQ-007 B_Inp  input  1  raw load button (asynchronous, bouncing).
REQ-008 C_Inp  input  1  raw clear button.
REQ-009 P_Inp  input  1  raw replay button (used only with replay compiled in).
REQ-010 Switch  input  DOTS  braille dot switches, bit0 = dot1.
REQ-011 Seg_Out  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-012 Seg_En  output  1  display valid; Seg_Out SHALL be 0 when low.
REQ-013 Count  output  $clog2(DEPTH)+1  letters stored.
REQ-014 Full  output  1  Count == DEPTH.
REQ-015 Err  output  1  one-cycle pulse on rejected load.

Function
REQ-016 Each raw button SHALL pass a 2-flop synchroniser, then a debouncer producing one 1-cycle pulse per accepted press, none on release; press-to-pulse latency 2+DEB_CYCLES+1 cycles.
REQ-017 On load pulse, Switch SHALL be sampled that cycle and decoded to letter index 0..25 (a..z, standard grade-1 braille); any other pattern SHALL decode as invalid.
REQ-018 Valid letter with Full low SHALL be written at wr_ptr, wr_ptr incremented modulo DEPTH, Count incremented; Seg_Out/Seg_En SHALL show the letter glyph the cycle after the pulse.
REQ-019 Invalid pattern, or valid letter with Full high, SHALL leave buffer, Count and display unchanged and pulse Err the cycle after the load pulse.
REQ-020 Clear pulse SHALL set Count=0, wr_ptr=0, Seg_En=0 the following cycle, from any state.
REQ-021 Clear and load pulses in the same cycle: clear SHALL win; load discarded, no Err.
REQ-022 States: IDLE (display last letter or blank), REPLAY (replay build only).
REQ-023 IDLE->REPLAY on replay pulse with Count>0; replay pulse with Count=0 SHALL be ignored.
REQ-024 REPLAY SHALL display entries oldest to newest, each for exactly HOLD_CYCLES cycles, then return to IDLE showing newest entry.
REQ-025 In REPLAY, load and replay pulses SHALL be ignored (no Err); clear SHALL abort to IDLE with blank display.
REQ-026 Oldest entry index = (wr_ptr - Count) modulo DEPTH; pointer arithmetic SHALL wrap without overflow.

Reset
REQ-027 Rst SHALL force: state IDLE, Count=0, pointers 0, Seg_Out=0, Seg_En=0, Full=0, Err=0, debouncers to released, replay timer 0; buffer contents need not be cleared.
REQ-028 Rst mid-replay or mid-debounce SHALL abort with no pulse emitted in the following cycle.

Configuration
REQ-029 Macro BRAILLE_REPLAY_EN: defined -> REPLAY state, replay timer and P_Inp debouncer present; undefined -> P_Inp unconnected internally, block never leaves IDLE, all other behaviour identical.

Structure
REQ-030 Package braille_pkg SHALL hold the state enum, letter-index type, INVALID code (5'd31), braille-to-letter table and letter-to-glyph table.
REQ-031 One sub-module braille_btn_deb (synchroniser + debouncer + pulse), instantiated per button.

Verification (DOTS=6, DEPTH=4, DEB_CYCLES=4, HOLD_CYCLES=8)
REQ-032 Reset, Switch=6'b000001, press B_Inp with 3 bounces -> exactly one load; Count=1, Seg_Out = glyph 'a', Seg_En=1.
REQ-033 Load 6'b000011,6'b001001,6'b011001,6'b010001 ('b','c','d','e') -> Count=4, Full=1; fifth load 6'b000001 -> Err one cycle, Count stays 4.
REQ-034 Load Switch=6'b111111 -> Err one cycle, display and Count unchanged.
REQ-035 Replay build, buffer 'b','c','d' after one earlier wrap -> each shown 8 cycles in order b,c,d, then IDLE showing 'd'; load during replay ignored.
REQ-036 Clear and load pulses same cycle with Count=2 -> Count=0, Seg_En=0, Err=0.
REQ-037 Rst asserted during replay -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/braille_pkg.sv
// Shared types and tables for the braille learning controller.
// Holds the state enum, letter index type, INVALID code, decode and glyph tables.
package braille_pkg;

   typedef enum logic {
      IDLE,
      REPLAY
   } state_t;

   typedef logic [4:0] letter_t;

   localparam letter_t INVALID = 5'd31;

   // Segment glyphs {g,f,e,d,c,b,a} for letters a..z.
   localparam logic [6:0] GLYPH_TAB [26] = '{
      7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
      7'h3D, 7'h74, 7'h30, 7'h1E, 7'h75, 7'h38,
      7'h55, 7'h54, 7'h5C, 7'h73, 7'h67, 7'h50,
      7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h6A, 7'h76,
      7'h6E, 7'h5B
   };

   // Grade-1 braille, bit0 = dot1 .. bit5 = dot6.
   function automatic letter_t brl_decode(input logic [5:0] dots);
      letter_t l;
      case (dots)
         6'b000001: l = 5'd0;
         6'b000011: l = 5'd1;
         6'b001001: l = 5'd2;
         6'b011001: l = 5'd3;
         6'b010001: l = 5'd4;
         6'b001011: l = 5'd5;
         6'b011011: l = 5'd6;
         6'b010011: l = 5'd7;
         6'b001010: l = 5'd8;
         6'b011010: l = 5'd9;
         6'b000101: l = 5'd10;
         6'b000111: l = 5'd11;
         6'b001101: l = 5'd12;
         6'b011101: l = 5'd13;
         6'b010101: l = 5'd14;
         6'b001111: l = 5'd15;
         6'b011111: l = 5'd16;
         6'b010111: l = 5'd17;
         6'b001110: l = 5'd18;
         6'b011110: l = 5'd19;
         6'b100101: l = 5'd20;
         6'b100111: l = 5'd21;
         6'b111010: l = 5'd22;
         6'b101101: l = 5'd23;
         6'b111101: l = 5'd24;
         6'b110101: l = 5'd25;
         default:   l = INVALID;
      endcase
      return l;
   endfunction

   function automatic logic [6:0] letter_glyph(input letter_t l);
      logic [6:0] g;
      g = '0;
      if (l < 5'd26)
         g = GLYPH_TAB[l];
      return g;
   endfunction

endpackage

// File: rtl/braille_btn_deb.sv
// Button conditioner: 2-flop synchroniser, stability debouncer, press pulse.
// Ports: clk, rst (sync, active-high), raw (async button), pulse (1 cycle per press).
module braille_btn_deb #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   // A new level is accepted only after DEB_CYCLES consecutive
   // synchronised samples disagree with the accepted level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         pulse <= 1'b0;
         if (sync[1] != level) begin
            if (cnt == CW'(DEB_CYCLES - 1)) begin
               level <= sync[1];
               cnt   <= '0;
               pulse <= sync[1];
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/braille_learn_ctrl.sv
// Braille learning controller: load letters from dot switches, show on 7-seg, replay.
// Ports: Clk, Rst, B_Inp/C_Inp/P_Inp buttons, Switch dots; Seg_Out, Seg_En, Count, Full, Err.
// Macro BRAILLE_REPLAY_EN enables the REPLAY state and the P_Inp debouncer.
module braille_learn_ctrl
   import braille_pkg::*;
#(
   parameter int DOTS        = 6,
   parameter int DEPTH       = 8,
   parameter int DEB_CYCLES  = 16,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     B_Inp,
   input  logic                     C_Inp,
   input  logic                     P_Inp,
   input  logic [DOTS-1:0]          Switch,
   output logic [6:0]               Seg_Out,
   output logic                     Seg_En,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Full,
   output logic                     Err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(HOLD_CYCLES + 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, left, left_n;
   logic [PW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [PW-1:0] oldest, nxt_rd;
   logic [TW-1:0] tmr, tmr_n;
   letter_t       cur, cur_n, lt;
   logic          en, en_n, err, err_n, we, full;
   logic          load_p, clr_p, rep_p;
   logic          unused_in;
   letter_t       mem [DEPTH];

   braille_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk(Clk), .rst(Rst), .raw(B_Inp), .pulse(load_p)
   );

   braille_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (
      .clk(Clk), .rst(Rst), .raw(C_Inp), .pulse(clr_p)
   );

`ifdef BRAILLE_REPLAY_EN
   braille_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p (
      .clk(Clk), .rst(Rst), .raw(P_Inp), .pulse(rep_p)
   );
   assign unused_in = ^Switch;
`else
   assign rep_p     = 1'b0;
   assign unused_in = ^{P_Inp, Switch};
`endif

   // Dots 7/8 never take part in decoding.
   assign lt     = brl_decode(Switch[5:0]);
   assign full   = (cnt == CW'(DEPTH));
   assign oldest = wr_ptr - cnt[PW-1:0];
   assign nxt_rd = rd_ptr + PW'(1);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      left_n   = left;
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      tmr_n    = tmr;
      cur_n    = cur;
      en_n     = en;
      err_n    = 1'b0;
      we       = 1'b0;
      if (clr_p) begin
         state_n  = IDLE;
         cnt_n    = '0;
         wr_ptr_n = '0;
         tmr_n    = '0;
         en_n     = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_p) begin
                  if (lt == INVALID || full) begin
                     err_n = 1'b1;
                  end else begin
                     we       = 1'b1;
                     wr_ptr_n = wr_ptr + PW'(1);
                     cnt_n    = cnt + CW'(1);
                     cur_n    = lt;
                     en_n     = 1'b1;
                  end
               end else if (rep_p && cnt != '0) begin
                  state_n  = REPLAY;
                  rd_ptr_n = oldest;
                  cur_n    = mem[oldest];
                  left_n   = cnt - CW'(1);
                  tmr_n    = '0;
                  en_n     = 1'b1;
               end
            end
            REPLAY: begin
               if (tmr == TW'(HOLD_CYCLES - 1)) begin
                  tmr_n = '0;
                  // Last entry is the newest, so IDLE keeps showing it.
                  if (left == '0) begin
                     state_n = IDLE;
                  end else begin
                     rd_ptr_n = nxt_rd;
                     cur_n    = mem[nxt_rd];
                     left_n   = left - CW'(1);
                  end
               end else begin
                  tmr_n = tmr + TW'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         cnt    <= '0;
         left   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         tmr    <= '0;
         cur    <= '0;
         en     <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         left   <= left_n;
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         tmr    <= tmr_n;
         cur    <= cur_n;
         en     <= en_n;
         err    <= err_n;
      end
   end

   always_ff @(posedge Clk) begin
      if (we)
         mem[wr_ptr] <= lt;
   end

   assign Seg_Out = en ? letter_glyph(cur) : '0;
   assign Seg_En  = en;
   assign Count   = cnt;
   assign Full    = full;
   assign Err     = err;

endmodule

// File: tb/tb_braille_learn_ctrl.sv
// Self-checking bench for braille_learn_ctrl with a queue-based letter model.
// Ports driven: Clk, Rst, B_Inp, C_Inp, P_Inp, Switch; replay checks need BRAILLE_REPLAY_EN.
module tb_braille_learn_ctrl;

   localparam int DEPTH = 4;
   localparam int DEB   = 4;
   localparam int HOLD  = 8;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       B_Inp = 1'b0;
   logic       C_Inp = 1'b0;
   logic       P_Inp = 1'b0;
   logic [5:0] Switch = '0;
   logic [6:0] Seg_Out;
   logic       Seg_En;
   logic [2:0] Count;
   logic       Full;
   logic       Err;

   braille_learn_ctrl #(
      .DOTS(6), .DEPTH(DEPTH), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)
   ) dut (
      .Clk(Clk), .Rst(Rst), .B_Inp(B_Inp), .C_Inp(C_Inp),
      .P_Inp(P_Inp), .Switch(Switch), .Seg_Out(Seg_Out),
      .Seg_En(Seg_En), .Count(Count), .Full(Full), .Err(Err)
   );

   always #5 Clk = ~Clk;

   logic [5:0] BRL [26] = '{
      6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001,
      6'b001011, 6'b011011, 6'b010011, 6'b001010, 6'b011010,
      6'b000101, 6'b000111, 6'b001101, 6'b011101, 6'b010101,
      6'b001111, 6'b011111, 6'b010111, 6'b001110, 6'b011110,
      6'b100101, 6'b100111, 6'b111010, 6'b101101, 6'b111101,
      6'b110101
   };
   logic [6:0] GLY [26] = '{
      7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
      7'h3D, 7'h74, 7'h30, 7'h1E, 7'h75, 7'h38,
      7'h55, 7'h54, 7'h5C, 7'h73, 7'h67, 7'h50,
      7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h6A, 7'h76,
      7'h6E, 7'h5B
   };

   int n_chk = 0;
   int n_fail = 0;
   int err_seen = 0;
   int q[$];
   int m_let = 0;
   bit m_en = 1'b0;

   always @(negedge Clk)
      if (Err === 1'b1) err_seen++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int decode(input logic [5:0] d);
      for (int i = 0; i < 26; i++)
         if (BRL[i] == d) return i;
      return -1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic drv(input logic [2:0] m, input logic v);
      if (m[0]) B_Inp = v;
      if (m[1]) C_Inp = v;
      if (m[2]) P_Inp = v;
   endtask

   // Bounce glitches last at most 2 cycles, shorter than the debounce window.
   task automatic press(input logic [2:0] m, input int nb);
      for (int i = 0; i < nb; i++) begin
         drv(m, 1'b1); cyc($urandom_range(1, 2));
         drv(m, 1'b0); cyc($urandom_range(1, 2));
      end
      drv(m, 1'b1); cyc(DEB + 4);
      for (int i = 0; i < nb; i++) begin
         drv(m, 1'b0); cyc($urandom_range(1, 2));
         drv(m, 1'b1); cyc($urandom_range(1, 2));
      end
      drv(m, 1'b0); cyc(DEB + 6);
   endtask

   task automatic check_outs(input string tag);
      @(negedge Clk);
      chk({tag, ".count"}, Count, q.size());
      chk({tag, ".full"}, Full, q.size() == DEPTH);
      chk({tag, ".en"}, Seg_En, m_en);
      chk({tag, ".seg"}, Seg_Out, m_en ? GLY[m_let] : 7'h00);
   endtask

   task automatic do_op(input logic [2:0] m, input logic [5:0] sw,
                        input int nb, input string tag);
      int e0, l, exp_err;
      exp_err = 0;
      Switch = sw;
      e0 = err_seen;
      press(m, nb);
      if (m[1]) begin
         q.delete();
         m_en = 1'b0;
      end else if (m[0]) begin
         l = decode(sw);
         if (l < 0 || q.size() == DEPTH) begin
            exp_err = 1;
         end else begin
            q.push_back(l);
            m_let = l;
            m_en = 1'b1;
         end
      end
      check_outs(tag);
      chk({tag, ".err"}, err_seen - e0, exp_err);
   endtask

   task automatic rst_check(input string tag);
      Rst = 1'b1;
      @(negedge Clk);
      chk({tag, ".count"}, Count, 0);
      chk({tag, ".full"}, Full, 0);
      chk({tag, ".en"}, Seg_En, 0);
      chk({tag, ".seg"}, Seg_Out, 0);
      chk({tag, ".err"}, Err, 0);
      Rst = 1'b0;
      q.delete();
      m_en = 1'b0;
   endtask

`ifdef BRAILLE_REPLAY_EN
   task automatic replay_run(input bit with_load, input string tag);
      int n, e0;
      bit seen;
      logic [6:0] tr[$];
      n = q.size();
      e0 = err_seen;
      seen = 1'b0;
      Switch = 6'b000001;
      fork
         press(3'b100, 2);
         begin
            for (int i = 0; i < 80 && !seen; i++) begin
               @(negedge Clk);
               if (Seg_Out == GLY[q[0]]) seen = 1'b1;
            end
            chk({tag, ".start"}, seen, 1);
            if (seen) begin
               tr.push_back(Seg_Out);
               for (int i = 1; i < 8 * n + 4; i++) begin
                  @(negedge Clk);
                  tr.push_back(Seg_Out);
               end
            end
         end
         if (with_load) begin
            for (int i = 0; i < 80 && !seen; i++)
               @(negedge Clk);
            if (seen) begin
               cyc(2);
               press(3'b001, 0);
            end
         end
      join
      for (int i = 0; i < tr.size(); i++)
         chk($sformatf("%s.tr%0d", tag, i), tr[i],
             GLY[q[(i / HOLD < n) ? i / HOLD : n - 1]]);
      check_outs({tag, ".end"});
      chk({tag, ".err"}, err_seen - e0, 0);
   endtask

   task automatic rst_in_replay();
      bit seen;
      seen = 1'b0;
      fork
         press(3'b100, 0);
         begin
            for (int i = 0; i < 80 && !seen; i++) begin
               @(negedge Clk);
               if (Seg_Out == GLY[q[0]]) seen = 1'b1;
            end
            chk("rrep.start", seen, 1);
            rst_check("rrep");
         end
      join
      check_outs("rrep.after");
   endtask
`endif

   initial begin
      int lat, r;
      logic [5:0] sw;

      cyc(3);
      rst_check("reset");
      cyc(1);

      do_op(3'b001, 6'b000001, 3, "load_a");
      do_op(3'b001, 6'b000011, $urandom_range(0, 3), "load_b");
      do_op(3'b001, 6'b001001, $urandom_range(0, 3), "load_c");
      do_op(3'b001, 6'b011001, $urandom_range(0, 3), "load_d");
      do_op(3'b001, 6'b010001, $urandom_range(0, 3), "load_e");
      do_op(3'b001, 6'b000001, 1, "full_rej");
      do_op(3'b010, 6'b000000, 1, "clear");

      cyc(1);
      Switch = 6'b000001;
      B_Inp = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         cyc(1);
         if (Count != 0) lat = i;
      end
      chk("latency", lat, 2 + DEB + 1);
      B_Inp = 1'b0;
      cyc(DEB + 6);
      q.push_back(0);
      m_let = 0;
      m_en = 1'b1;
      check_outs("lat");

      do_op(3'b001, 6'b111111, 1, "invalid");
      do_op(3'b001, 6'b000011, 0, "load2");
      do_op(3'b011, 6'b000001, 0, "clr_ld");

`ifdef BRAILLE_REPLAY_EN
      do_op(3'b001, 6'b000011, 1, "rb");
      do_op(3'b001, 6'b001001, 1, "rc");
      do_op(3'b001, 6'b011001, 1, "rd");
      replay_run(1'b1, "rep3");
      do_op(3'b001, 6'b000001, 0, "post");
      replay_run(1'b0, "rep4");
      rst_in_replay();
`else
      do_op(3'b001, 6'b000011, 1, "nb");
      do_op(3'b001, 6'b001001, 1, "nc");
      do_op(3'b100, 6'b000000, 2, "norep");
      rst_check("rst2");
`endif
      do_op(3'b100, 6'b000000, 1, "rep0");

      // Reset one sample before the debouncer would accept the press.
      cyc(1);
      Switch = 6'b000001;
      B_Inp = 1'b1;
      cyc(2 + DEB - 1);
      Rst = 1'b1;
      cyc(1);
      Rst = 1'b0;
      B_Inp = 1'b0;
      cyc(DEB + 6);
      check_outs("rst_deb");

      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 99);
         sw = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                          : BRL[$urandom_range(0, 25)];
         if (r < 70)
            do_op(3'b001, sw, $urandom_range(0, 3), $sformatf("rl%0d", k));
         else if (r < 88)
            do_op(3'b010, sw, $urandom_range(0, 3), $sformatf("rc%0d", k));
         else
            do_op(3'b011, sw, $urandom_range(0, 3), $sformatf("rx%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
